i2s_tx: RTL
===========

# i2s_tx

Stereo I2S transmitter feeding the DECA on-board audio codec from the core's parallel 16-bit DAC_L/DAC_R samples. It runs on the 50 MHz board clock and generates MCLK, bit clock, word clock and serial data. It sits between the core's audio outputs and the codec pins I2S_MCK/I2S_SCK/I2S_LR/I2S_D; the codec itself is configured separately over SPI.

## Interface
- SCK_HALF, default 8: SCK half-period in clk_50MHz cycles, ≥2. Default gives SCK 3.125 MHz and fs ≈ 48.8 kHz.
- clk_50MHz  input  1: board clock, 50 MHz; only clock.
- reset  input  1: asynchronous, active-high reset.
- L_data  input  16: left sample, two's complement, sampled by the block.
- R_data  input  16: right sample, two's complement, sampled by the block.
- dac_MCLK  output  1: codec master clock, clk_50MHz/2.
- dac_SCLK  output  1: I2S bit clock.
- dac_LRCK  output  1: word select; 0 = left, 1 = right.
- dac_SDIN  output  1: serial data, MSB first.
- sample_tick  output  1: one-cycle pulse when L_data/R_data are latched.

## Operation
- Frame: 64 SCK periods, 32 slot bits per channel, left slot first. Standard I2S: MSB one SCK after the LRCK edge.
- Counters:
  - div_cnt counts 0..SCK_HALF-1 and wraps. At wrap, SCK toggles.
  - bit_cnt[5:0] advances on every SCK falling edge and wraps 63→0.
- LRCK = bit_cnt[5], updated on SCK falling edges.
- Slot bit k = bit_cnt[4:0]:
  - k = 1..16: SDIN = shadow[16-k], where shadow is the left or right shadow register.
  - k = 0 and k = 17..31: SDIN = 0.
- Latch: on the falling edge where bit_cnt becomes 0, copy L_data and R_data into both shadow registers simultaneously. sample_tick pulses in that same cycle. Inputs are assumed stable or synchronous to clk_50MHz; no CDC is done here.
- MCLK: free-running toggle flop, independent of the frame counters.

## Timing
- Reset values: dac_MCLK, dac_SCLK, dac_LRCK, dac_SDIN, sample_tick = 0. div_cnt = 0, bit_cnt = 0, shadows = 0.
- After reset release:
  - first SCK rising edge after SCK_HALF clk cycles;
  - first falling edge after 2·SCK_HALF cycles; bit_cnt then goes 0→1.
  - The first frame transmits zero shadows.
  - The first latch occurs at the bit_cnt 63→0 transition, 64·2·SCK_HALF cycles after release.
- SDIN and LRCK change only in the cycle SCK falls. The codec samples on the rising edge with ≥SCK_HALF−1 cycles of setup.
- Input-to-pin latency: a sample latched at frame start reaches the MSB on SDIN one SCK period later (left) or 33 SCK periods later (right).
- All outputs are registered, with no combinational path from inputs.
- Reset asserted mid-frame: everything clears immediately and the frame is discarded. No partial word resumes.
- An input change at the latch cycle takes the value present at that clock edge.

## Configuration
- I2S_TX_MONO_EN defined:
  - Both shadow registers load m = (sext17(L_data) + sext17(R_data)) >>> 1.
  - This is an arithmetic shift of the 17-bit sum; keep bits [15:0]. No overflow is possible.
  - Example: 0x7FFF + 0x7FFF → 0x7FFF; 0x8000 + 0x7FFF → 0xFFFF.
- Undefined: independent L/R as described in Operation. Timing is identical in both builds.

## Structure
- Shared package i2s_pkg holds:
  - localparam FRAME_BITS = 64, SLOT_BITS = 32, SAMPLE_W = 16;
  - typedef logic signed [SAMPLE_W-1:0] sample_t.
- One sub-module, i2s_clkgen: div_cnt, SCK and MCLK toggles. It exports sck_fall and sck_rise one-cycle strobes.
- The top keeps bit_cnt, the shadows and the SDIN mux.

## Test plan
- Reset release with L=0x1234, R=0xABCD held: first frame SDIN all 0. Second frame: left slot bits 1..16 carry 0x1234 MSB-first, right slot bits carry 0xABCD. LRCK is 0 for 32 SCK, then 1 for 32 SCK.
- Clock ratios at SCK_HALF=8: SCK period 16 clk, MCLK period 2 clk, LRCK period 1024 clk. sample_tick pulses once per 1024 clk.
- L_data changes 0x0001→0x8000 at random cycles mid-frame: the transmitted word changes only at the next frame boundary, never mid-word.
- Assert reset at bit_cnt=20 of the right slot: all outputs 0 within the same edge. After release, timing restarts exactly as in the first scenario.
- With I2S_TX_MONO_EN and L=0x8000, R=0x7FFF: both slots carry 0xFFFF. With L=0x0100, R=0x0300: both slots carry 0x0200.
- Check for SCK_HALF=2 and SCK_HALF=8: SDIN/LRCK toggle only in the cycle SCK falls, and are never X after reset.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants and sample type for the I2S transmitter.
// Optional build macro: I2S_TX_MONO_EN (mono downmix of L/R into both slots).
package i2s_pkg;
  localparam int FRAME_BITS = 64;
  localparam int SLOT_BITS  = 32;
  localparam int SAMPLE_W   = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Average of two samples: arithmetic shift of the 17-bit sum cannot overflow.
  function automatic sample_t mono_mix(sample_t l, sample_t r);
    logic signed [SAMPLE_W:0] s;
    logic signed [SAMPLE_W:0] h;
    s = {l[SAMPLE_W-1], l} + {r[SAMPLE_W-1], r};
    h = s >>> 1;
    return h[SAMPLE_W-1:0];
  endfunction
endpackage

// File: rtl/i2s_clkgen.sv
// SCK divider and MCLK toggle. The strobes are high in the cycle whose
// closing clock edge makes SCK rise/fall, so downstream registers that load
// on a strobe change in the same edge as SCK.
module i2s_clkgen #(
  parameter int SCK_HALF = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_mclk,
  output logic o_sck_rise,
  output logic o_sck_fall
);
  localparam int DW = (SCK_HALF < 2) ? 1 : $clog2(SCK_HALF);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCK_HALF - 1);

  logic [DW-1:0] r_div_cnt;
  logic          r_sck;
  logic          r_mclk;
  logic          w_wrap;

  assign w_wrap     = (r_div_cnt == DIV_MAX);
  assign o_sck_rise = w_wrap & ~r_sck;
  assign o_sck_fall = w_wrap &  r_sck;
  assign o_mclk     = r_mclk;

  // Half-period divider; SCK toggles whenever the divider wraps.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div_cnt <= '0;
      r_sck     <= 1'b0;
    end else if (w_wrap) begin
      r_div_cnt <= '0;
      r_sck     <= ~r_sck;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  // Free-running MCLK at half the board clock.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_mclk <= 1'b0;
    else       r_mclk <= ~r_mclk;
  end
endmodule

// File: rtl/i2s_tx.sv
// Stereo I2S transmitter: 64-SCK frames, 32-bit slots, 16-bit MSB-first
// data starting one SCK after the LRCK edge.
// Optional build macro: I2S_TX_MONO_EN loads the L/R average into both slots.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int SCK_HALF = 8
) (
  input  logic                clk_50MHz,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] L_data,
  input  logic [SAMPLE_W-1:0] R_data,
  output logic                dac_MCLK,
  output logic                dac_SCLK,
  output logic                dac_LRCK,
  output logic                dac_SDIN,
  output logic                sample_tick
);
  localparam int BW = $clog2(FRAME_BITS);
  localparam int KW = $clog2(SLOT_BITS);

  logic          w_sck_rise;
  logic          w_sck_fall;
  logic [BW-1:0] r_bit_cnt;
  logic [BW-1:0] w_next_bit;
  logic [KW-1:0] w_k;
  logic [3:0]    w_idx;
  logic          w_latch;
  logic          w_sdin_nxt;
  sample_t       r_sh_l;
  sample_t       r_sh_r;
  sample_t       w_src;
  sample_t       w_ld_l;
  sample_t       w_ld_r;
  logic          r_sclk;
  logic          r_lrck;
  logic          r_sdin;
  logic          r_tick;

  i2s_clkgen #(.SCK_HALF(SCK_HALF)) u_clkgen (
    .i_clk      (clk_50MHz),
    .i_rst      (reset),
    .o_mclk     (dac_MCLK),
    .o_sck_rise (w_sck_rise),
    .o_sck_fall (w_sck_fall)
  );

`ifdef I2S_TX_MONO_EN
  assign w_ld_l = mono_mix(sample_t'(L_data), sample_t'(R_data));
  assign w_ld_r = w_ld_l;
`else
  assign w_ld_l = sample_t'(L_data);
  assign w_ld_r = sample_t'(R_data);
`endif

  // Everything below looks at the bit that becomes current at this SCK fall.
  assign w_next_bit = r_bit_cnt + 1'b1;
  assign w_k        = w_next_bit[KW-1:0];
  assign w_idx      = 4'(5'd16 - 5'(w_k));
  assign w_src      = w_next_bit[BW-1] ? r_sh_r : r_sh_l;
  assign w_latch    = w_sck_fall && (w_next_bit == '0);

  // Data bits occupy slot positions 1..16; the rest of the slot is padding.
  always_comb begin
    w_sdin_nxt = 1'b0;
    if (w_k >= KW'(1) && w_k <= KW'(16)) w_sdin_nxt = w_src[w_idx];
  end

  // Frame position, word select and serial data advance on SCK falls.
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      r_bit_cnt <= '0;
      r_lrck    <= 1'b0;
      r_sdin    <= 1'b0;
    end else if (w_sck_fall) begin
      r_bit_cnt <= w_next_bit;
      r_lrck    <= w_next_bit[BW-1];
      r_sdin    <= w_sdin_nxt;
    end
  end

  // Both shadows load together at frame start so L and R stay paired.
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      r_sh_l <= '0;
      r_sh_r <= '0;
    end else if (w_latch) begin
      r_sh_l <= w_ld_l;
      r_sh_r <= w_ld_r;
    end
  end

  // Pin-side SCK register driven by the divider strobes, plus latch pulse.
  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      r_sclk <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      if (w_sck_rise)      r_sclk <= 1'b1;
      else if (w_sck_fall) r_sclk <= 1'b0;
      r_tick <= w_latch;
    end
  end

  assign dac_SCLK    = r_sclk;
  assign dac_LRCK    = r_lrck;
  assign dac_SDIN    = r_sdin;
  assign sample_tick = r_tick;
endmodule
